// File: rtl/controlador_barra_nivel.sv
// controlador_barra_nivel: level-bar controller for an N-segment fill column.
// Owns the level counter, the step timer and the blink source, and decodes
// the level into per-segment drive lines. The moving segment blinks and the
// segments below it stay lit.
module controlador_barra_nivel #(
  parameter int SEGS       = 7,
  parameter int STEP_DIV   = 50_000_000,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enche,
  input  logic                        esvazia,
  input  logic                        para,
  output logic [$clog2(SEGS+1)-1:0]   nivel,
  output logic [SEGS-1:0]             l,
  output logic                        ocupado,
  output logic                        cheio,
  output logic                        vazio,
  output logic                        fim
);

  localparam int NW = $clog2(SEGS + 1);
  localparam int SW = $clog2(STEP_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [NW-1:0] NIVEL_MAX  = NW'(SEGS);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic          LIT        = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NW-1:0]   nivel_nxt;
  logic [SW-1:0]   step_cnt;
  logic [SW-1:0]   step_nxt;
  logic [BW-1:0]   blink_cnt;
  logic [BW-1:0]   blink_nxt;
  logic            blink_ph;
  logic            blink_ph_nxt;
  logic            fim_nxt;
  logic            step_done;
  logic            entering;

  // State, level, timers and the end-of-run pulse all live in one register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      nivel     <= '0;
      step_cnt  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      fim       <= 1'b0;
    end else begin
      state     <= state_nxt;
      nivel     <= nivel_nxt;
      step_cnt  <= step_nxt;
      blink_cnt <= blink_nxt;
      blink_ph  <= blink_ph_nxt;
      fim       <= fim_nxt;
    end
  end

  // Command arbitration (para > enche > esvazia) and level stepping; a step
  // is only taken when no state change wins the same edge.
  always_comb begin
    state_nxt = state;
    nivel_nxt = nivel;
    fim_nxt   = 1'b0;
    step_done = (step_cnt == STEP_LAST);
    case (state)
      S_FILL: begin
        if (para) begin
          state_nxt = S_IDLE;
        end else if (!enche && esvazia && (nivel != '0)) begin
          state_nxt = S_DRAIN;
        end else if (step_done) begin
          nivel_nxt = nivel + NW'(1);
          if (nivel_nxt == NIVEL_MAX) begin
            state_nxt = S_IDLE;
            fim_nxt   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (para) begin
          state_nxt = S_IDLE;
        end else if (enche && (nivel != NIVEL_MAX)) begin
          state_nxt = S_FILL;
        end else if (step_done) begin
          nivel_nxt = nivel - NW'(1);
          if (nivel_nxt == '0) begin
            state_nxt = S_IDLE;
            fim_nxt   = 1'b1;
          end
        end
      end
      default: begin
        if (para) begin
          state_nxt = S_IDLE;
        end else if (enche) begin
          if (nivel != NIVEL_MAX) begin
            state_nxt = S_FILL;
          end
        end else if (esvazia && (nivel != '0)) begin
          state_nxt = S_DRAIN;
        end
      end
    endcase
  end

  // Step timer and blink source restart on every state entry.
  always_comb begin
    entering     = (state_nxt != state);
    step_nxt     = step_cnt + SW'(1);
    blink_nxt    = blink_cnt + BW'(1);
    blink_ph_nxt = blink_ph;
    if (entering || (state == S_IDLE) || step_done) begin
      step_nxt = '0;
    end
    if (entering) begin
      blink_nxt    = '0;
      blink_ph_nxt = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_nxt    = '0;
      blink_ph_nxt = ~blink_ph;
    end
  end

  // Status flags come straight from the registers.
  always_comb begin
    ocupado = (state != S_IDLE);
    cheio   = (nivel == NIVEL_MAX);
    vazio   = (nivel == '0);
  end

  // Segment decode: bar position k drives l[SEGS-1-k].
  always_comb begin
    l = {SEGS{~LIT}};
    for (int k = 0; k < SEGS; k++) begin
      case (state)
        S_FILL: begin
          if (k < int'(nivel)) begin
            l[SEGS-1-k] = LIT;
          end else if (k == int'(nivel)) begin
            l[SEGS-1-k] = blink_ph ? LIT : ~LIT;
          end
        end
        S_DRAIN: begin
          if (k < int'(nivel) - 1) begin
            l[SEGS-1-k] = LIT;
          end else if (k == int'(nivel) - 1) begin
            l[SEGS-1-k] = blink_ph ? LIT : ~LIT;
          end
        end
        default: begin
          if (k < int'(nivel)) begin
            l[SEGS-1-k] = LIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_barra_nivel.sv
// Testbench for controlador_barra_nivel with SEGS=7, STEP_DIV=4, BLINK_DIV=2,
// ACTIVE_LOW=1. Expected outputs are queued before each edge and compared
// just after it.
module tb_controlador_barra_nivel;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_FILL  = 1;
  localparam int MODE_DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enche;
  logic       esvazia;
  logic       para;
  logic [2:0] nivel;
  logic [6:0] l;
  logic       ocupado;
  logic       cheio;
  logic       vazio;
  logic       fim;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         nivel;
    logic [6:0] l;
    logic       ocupado;
    logic       fim;
  } exp_t;

  exp_t sb[$];

  controlador_barra_nivel #(
    .SEGS(7),
    .STEP_DIV(4),
    .BLINK_DIV(2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enche(enche),
    .esvazia(esvazia),
    .para(para),
    .nivel(nivel),
    .l(l),
    .ocupado(ocupado),
    .cheio(cheio),
    .vazio(vazio),
    .fim(fim)
  );

  always #5 clk = ~clk;

  // Lit segments drive 0; position k sits on l[6-k].
  function automatic logic [6:0] expL(int mode, int n, bit ph);
    int pos;
    logic [6:0] r;
    case (mode)
      MODE_IDLE: pos = (1 << n) - 1;
      MODE_FILL: begin
        pos = (1 << n) - 1;
        if (ph) pos = pos | (1 << n);
      end
      default: begin
        pos = (1 << (n - 1)) - 1;
        if (ph) pos = pos | (1 << (n - 1));
      end
    endcase
    for (int k = 0; k < 7; k++) r[6-k] = ~pos[k];
    return r;
  endfunction

  // Blink phase i edges after a state entry, with a 2-cycle half-period.
  function automatic bit phase(int i);
    return ((i / 2) % 2) == 0;
  endfunction

  task automatic pushExp(string tag, int mode, int n, bit ph, bit f);
    exp_t e;
    e.tag     = tag;
    e.nivel   = n;
    e.l       = expL(mode, n, ph);
    e.ocupado = (mode != MODE_IDLE);
    e.fim     = f;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(bit e, bit v, bit p);
    enche   = e;
    esvazia = v;
    para    = p;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (nivel === 3'(e.nivel)) else begin
        failures++;
        $error("FAIL %s_nivel got=%0d exp=%0d", e.tag, nivel, e.nivel);
      end
      checks++;
      assert (l === e.l) else begin
        failures++;
        $error("FAIL %s_l got=%b exp=%b", e.tag, l, e.l);
      end
      checks++;
      assert (ocupado === e.ocupado) else begin
        failures++;
        $error("FAIL %s_ocupado got=%b exp=%b", e.tag, ocupado, e.ocupado);
      end
      checks++;
      assert (fim === e.fim) else begin
        failures++;
        $error("FAIL %s_fim got=%b exp=%b", e.tag, fim, e.fim);
      end
      checks++;
      assert (cheio === (e.nivel == 7)) else begin
        failures++;
        $error("FAIL %s_cheio got=%b exp=%b", e.tag, cheio, (e.nivel == 7));
      end
      checks++;
      assert (vazio === (e.nivel == 0)) else begin
        failures++;
        $error("FAIL %s_vazio got=%b exp=%b", e.tag, vazio, (e.nivel == 0));
      end
    end
  endtask

  task automatic tickCheck();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Full run from empty with a one-cycle enche pulse.
  task automatic runFullFill(string tag);
    applyStimulus(1, 0, 0);
    pushExp({tag, "_start"}, MODE_FILL, 0, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 1; i < 28; i++) begin
      pushExp({tag, "_fill"}, MODE_FILL, i / 4, phase(i), 0);
      tickCheck();
    end
    pushExp({tag, "_full"}, MODE_IDLE, 7, 1, 1);
    tickCheck();
    pushExp({tag, "_fimoff"}, MODE_IDLE, 7, 1, 0);
    tickCheck();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    #12;
    pushExp("reset", MODE_IDLE, 0, 1, 0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: fill from empty to full.
    @(posedge clk);
    #1;
    runFullFill("s1");

    // Scenario 2: drain from full to empty.
    applyStimulus(0, 1, 0);
    pushExp("s2_start", MODE_DRAIN, 7, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 1; i < 28; i++) begin
      pushExp("s2_drain", MODE_DRAIN, 7 - i / 4, phase(i), 0);
      tickCheck();
    end
    pushExp("s2_empty", MODE_IDLE, 0, 1, 1);
    tickCheck();
    pushExp("s2_fimoff", MODE_IDLE, 0, 1, 0);
    tickCheck();

    // Scenario 3: para on the edge of the fourth step.
    applyStimulus(1, 0, 0);
    pushExp("s3_start", MODE_FILL, 0, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      pushExp("s3_fill", MODE_FILL, i / 4, phase(i), 0);
      tickCheck();
    end
    applyStimulus(0, 0, 1);
    pushExp("s3_para", MODE_IDLE, 3, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      pushExp("s3_hold", MODE_IDLE, 3, 1, 0);
      tickCheck();
    end

    // Scenario 4: reversal on a step edge at nivel=2.
    rst = 1'b1;
    #2;
    pushExp("s4_rst", MODE_IDLE, 0, 1, 0);
    checkOutput();
    rst = 1'b0;
    applyStimulus(1, 0, 0);
    pushExp("s4_start", MODE_FILL, 0, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 1; i < 12; i++) begin
      pushExp("s4_fill", MODE_FILL, i / 4, phase(i), 0);
      tickCheck();
    end
    applyStimulus(0, 1, 0);
    pushExp("s4_rev", MODE_DRAIN, 2, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int j = 1; j < 8; j++) begin
      pushExp("s4_drain", MODE_DRAIN, 2 - j / 4, phase(j), 0);
      tickCheck();
    end
    pushExp("s4_empty", MODE_IDLE, 0, 1, 1);
    tickCheck();
    pushExp("s4_fimoff", MODE_IDLE, 0, 1, 0);
    tickCheck();

    // Scenario 5: commands that cannot move the level are ignored.
    applyStimulus(0, 1, 0);
    pushExp("s5_esv_empty", MODE_IDLE, 0, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    pushExp("s5_idle_empty", MODE_IDLE, 0, 1, 0);
    tickCheck();
    runFullFill("s5");
    applyStimulus(1, 0, 0);
    pushExp("s5_enche_full", MODE_IDLE, 7, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    pushExp("s5_idle_full", MODE_IDLE, 7, 1, 0);
    tickCheck();

    // Scenario 6: asynchronous reset mid-fill at nivel=4.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    applyStimulus(1, 0, 0);
    pushExp("s6_start", MODE_FILL, 0, 1, 0);
    tickCheck();
    applyStimulus(0, 0, 0);
    for (int i = 1; i < 18; i++) begin
      pushExp("s6_fill", MODE_FILL, i / 4, phase(i), 0);
      tickCheck();
    end
    #2;
    rst = 1'b1;
    #1;
    pushExp("s6_rst", MODE_IDLE, 0, 1, 0);
    checkOutput();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pushExp("s6_after", MODE_IDLE, 0, 1, 0);
      tickCheck();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
